// File: rtl/sdram_init_seq_if.sv
// SDRAM command/address pin bundle driven by the power-up init sequencer.
// master = sequencer side (drives pins), slave = observer/SDRAM side.
interface sdram_init_seq_if;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [1:0]  ba;
    logic [12:0] addr;

    modport master (
        output cke, cs_n, ras_n, cas_n, we_n, ba, addr
    );

    modport slave (
        input cke, cs_n, ras_n, cas_n, we_n, ba, addr
    );
endinterface

// File: rtl/sdram_init_seq.sv
// DE1 SDRAM power-up sequencer: NOP wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE.
// Optional macro SDRAM_INIT_LOCK_SYNC_EN adds a 2-flop synchroniser on pll_locked.
module sdram_init_seq #(
    parameter int          CLK_MHZ       = 100,
    parameter int          POWERUP_US    = 200,
    parameter int          T_RP          = 2,
    parameter int          T_RFC         = 7,
    parameter int          T_MRD         = 2,
    parameter int          REFRESH_COUNT = 2,
    parameter logic [12:0] MODE_REG      = 13'h030
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pll_locked,
    sdram_init_seq_if.master         sdram,
    output logic                     ctrl_rst,
    output logic                     init_done
);

    localparam int P  = POWERUP_US * CLK_MHZ;
    localparam int CW = $clog2(P + 1);
    localparam int RW = $clog2(REFRESH_COUNT + 1);

    // Wait states hold for spacing-1 cycles, so they load spacing-2 on entry.
    localparam logic [CW-1:0] P_LOAD   = CW'(P - 1);
    localparam logic [CW-1:0] RP_LOAD  = CW'((T_RP  >= 2) ? T_RP  - 2 : 0);
    localparam logic [CW-1:0] RFC_LOAD = CW'((T_RFC >= 2) ? T_RFC - 2 : 0);
    localparam logic [CW-1:0] MRD_LOAD = CW'((T_MRD >= 2) ? T_MRD - 2 : 0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [RW-1:0] REF_ONE  = RW'(1);
    localparam logic [RW-1:0] REF_N    = RW'(REFRESH_COUNT);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_COUNT - 1);

    typedef enum logic [3:0] {
        S_WAIT_LOCK,
        S_POWERUP,
        S_PRECHARGE,
        S_WAIT_RP,
        S_REFRESH,
        S_WAIT_RFC,
        S_LOAD_MODE,
        S_WAIT_MRD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   ref_q, ref_d;
    logic            lk;

    logic            cke_q, cs_n_q, ras_n_q, cas_n_q, we_n_q;
    logic [1:0]      ba_q;
    logic [12:0]     addr_q;
    logic            ctrl_rst_q, init_done_q;

`ifdef SDRAM_INIT_LOCK_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
        end
    end

    assign lk = sync2_q;
`else
    assign lk = pll_locked;
`endif

    // Lock loss from any state, DONE included, restarts the whole sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        if (!lk) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            ref_d   = '0;
        end else begin
            case (state_q)
                S_WAIT_LOCK: begin
                    state_d = S_POWERUP;
                    cnt_d   = P_LOAD;
                end
                S_POWERUP: begin
                    if (cnt_q == '0) begin
                        state_d = S_PRECHARGE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_PRECHARGE: begin
                    ref_d = '0;
                    if (T_RP > 1) begin
                        state_d = S_WAIT_RP;
                        cnt_d   = RP_LOAD;
                    end else begin
                        state_d = S_REFRESH;
                    end
                end
                S_WAIT_RP: begin
                    if (cnt_q == '0) begin
                        state_d = S_REFRESH;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_REFRESH: begin
                    ref_d = ref_q + REF_ONE;
                    if (T_RFC > 1) begin
                        state_d = S_WAIT_RFC;
                        cnt_d   = RFC_LOAD;
                    end else if (ref_q == REF_LAST) begin
                        state_d = S_LOAD_MODE;
                    end else begin
                        state_d = S_REFRESH;
                    end
                end
                S_WAIT_RFC: begin
                    if (cnt_q == '0) begin
                        state_d = (ref_q == REF_N) ? S_LOAD_MODE : S_REFRESH;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_LOAD_MODE: begin
                    if (T_MRD > 1) begin
                        state_d = S_WAIT_MRD;
                        cnt_d   = MRD_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_WAIT_MRD: begin
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                    ref_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so pins change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_WAIT_LOCK;
            cnt_q       <= '0;
            ref_q       <= '0;
            cke_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            ras_n_q     <= 1'b1;
            cas_n_q     <= 1'b1;
            we_n_q      <= 1'b1;
            ba_q        <= 2'b00;
            addr_q      <= 13'h0000;
            ctrl_rst_q  <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ref_q       <= ref_d;
            cke_q       <= 1'b1;
            cs_n_q      <= 1'b0;
            ras_n_q     <= 1'b1;
            cas_n_q     <= 1'b1;
            we_n_q      <= 1'b1;
            ba_q        <= 2'b00;
            addr_q      <= 13'h0000;
            ctrl_rst_q  <= 1'b1;
            init_done_q <= 1'b0;
            case (state_d)
                S_WAIT_LOCK: begin
                    cke_q  <= 1'b0;
                    cs_n_q <= 1'b1;
                end
                S_PRECHARGE: begin
                    ras_n_q <= 1'b0;
                    we_n_q  <= 1'b0;
                    addr_q  <= 13'h0400;
                end
                S_REFRESH: begin
                    ras_n_q <= 1'b0;
                    cas_n_q <= 1'b0;
                end
                S_LOAD_MODE: begin
                    ras_n_q <= 1'b0;
                    cas_n_q <= 1'b0;
                    we_n_q  <= 1'b0;
                    addr_q  <= MODE_REG;
                end
                S_DONE: begin
                    ctrl_rst_q  <= 1'b0;
                    init_done_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign sdram.cke   = cke_q;
    assign sdram.cs_n  = cs_n_q;
    assign sdram.ras_n = ras_n_q;
    assign sdram.cas_n = cas_n_q;
    assign sdram.we_n  = we_n_q;
    assign sdram.ba    = ba_q;
    assign sdram.addr  = addr_q;
    assign ctrl_rst    = ctrl_rst_q;
    assign init_done   = init_done_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq with P=100: constant vector table, corner sequences,
// and random lock/reset traffic checked against a cycle-index reference model.
module tb_sdram_init_seq;

    localparam int          CLK_MHZ       = 100;
    localparam int          POWERUP_US    = 1;
    localparam int          T_RP          = 2;
    localparam int          T_RFC         = 7;
    localparam int          T_MRD         = 2;
    localparam int          REFRESH_COUNT = 2;
    localparam logic [12:0] MODE_REG      = 13'h030;
    localparam int          P             = POWERUP_US * CLK_MHZ;
    localparam int          L             = P + T_RP + REFRESH_COUNT * T_RFC;
`ifdef SDRAM_INIT_LOCK_SYNC_EN
    localparam int          LAT = 3;
`else
    localparam int          LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll_locked = 1'b0;
    logic ctrl_rst, init_done;

    sdram_init_seq_if sd ();

    sdram_init_seq #(
        .CLK_MHZ       (CLK_MHZ),
        .POWERUP_US    (POWERUP_US),
        .T_RP          (T_RP),
        .T_RFC         (T_RFC),
        .T_MRD         (T_MRD),
        .REFRESH_COUNT (REFRESH_COUNT),
        .MODE_REG      (MODE_REG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .sdram      (sd),
        .ctrl_rst   (ctrl_rst),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    // Packed view {cke, cs_n, ras_n, cas_n, we_n, ba, addr, ctrl_rst, init_done}.
    logic [21:0] actualOut;
    assign actualOut = {sd.cke, sd.cs_n, sd.ras_n, sd.cas_n, sd.we_n,
                        sd.ba, sd.addr, ctrl_rst, init_done};

    int checks = 0;
    int passes = 0;

    // Reference model: t is the sequence cycle index shown on the pins, -1 = waiting for lock.
    int   t = -1;
    logic s1 = 1'b0;
    logic s2 = 1'b0;
    logic [21:0] cap [0:199];

    function automatic logic [21:0] mk(input logic cke, input logic [3:0] cmd,
                                       input logic [12:0] addr, input logic crst,
                                       input logic done);
        return {cke, cmd, 2'b00, addr, crst, done};
    endfunction

    function automatic logic [21:0] expOut(input int tt);
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic        done;
        if (tt < 0) return mk(1'b0, 4'b1111, 13'h0, 1'b1, 1'b0);
        cmd  = 4'b0111;
        addr = 13'h0;
        done = (tt >= L + T_MRD);
        if (tt == P) begin
            cmd  = 4'b0010;
            addr = 13'h0400;
        end
        for (int k = 0; k < REFRESH_COUNT; k++)
            if (tt == P + T_RP + k * T_RFC) cmd = 4'b0001;
        if (tt == L) begin
            cmd  = 4'b0000;
            addr = MODE_REG;
        end
        return mk(1'b1, cmd, addr, ~done, done);
    endfunction

    task automatic modelStep();
        logic lkUse;
        if (rst) begin
            t  = -1;
            s1 = 1'b0;
            s2 = 1'b0;
        end else begin
`ifdef SDRAM_INIT_LOCK_SYNC_EN
            lkUse = s2;
            s2    = s1;
            s1    = pll_locked;
`else
            lkUse = pll_locked;
`endif
            if (!lkUse)          t = -1;
            else if (t < 0)      t = 0;
            else if (t < 100000) t = t + 1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic r, input logic l);
        rst        = r;
        pll_locked = l;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput($sformatf("model t=%0d @%0t", t, $time), 32'(actualOut), 32'(expOut(t)));
        if (t >= 0 && t < 200) cap[t] = actualOut;
    endtask

    task automatic clearCap();
        for (int i = 0; i < 200; i++) cap[i] = 'x;
    endtask

    typedef struct {
        int          cyc;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs [11];

    localparam logic [21:0] RESET_VAL = {1'b0, 4'b1111, 2'b00, 13'h0, 1'b1, 1'b0};

    initial begin
        int  count;
        logic lockState;

        vecs[0]  = '{0,   mk(1'b1, 4'b0111, 13'h0,    1'b1, 1'b0)};
        vecs[1]  = '{99,  mk(1'b1, 4'b0111, 13'h0,    1'b1, 1'b0)};
        vecs[2]  = '{100, mk(1'b1, 4'b0010, 13'h0400, 1'b1, 1'b0)};
        vecs[3]  = '{101, mk(1'b1, 4'b0111, 13'h0,    1'b1, 1'b0)};
        vecs[4]  = '{102, mk(1'b1, 4'b0001, 13'h0,    1'b1, 1'b0)};
        vecs[5]  = '{103, mk(1'b1, 4'b0111, 13'h0,    1'b1, 1'b0)};
        vecs[6]  = '{109, mk(1'b1, 4'b0001, 13'h0,    1'b1, 1'b0)};
        vecs[7]  = '{116, mk(1'b1, 4'b0000, 13'h030,  1'b1, 1'b0)};
        vecs[8]  = '{117, mk(1'b1, 4'b0111, 13'h0,    1'b1, 1'b0)};
        vecs[9]  = '{118, mk(1'b1, 4'b0111, 13'h0,    1'b0, 1'b1)};
        vecs[10] = '{125, mk(1'b1, 4'b0111, 13'h0,    1'b0, 1'b1)};

        $display("[TB] reset held with pll_locked=1");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("reset value", 32'(actualOut), 32'(RESET_VAL));

        $display("[TB] no lock for 1000 cycles");
        for (int i = 0; i < 1000; i++) applyStimulus(1'b0, 1'b0);

        $display("[TB] full sequence and lock latency");
        clearCap();
        applyStimulus(1'b0, 1'b1);
        count = 1;
        while (actualOut[21] !== 1'b1 && count < 10) begin
            applyStimulus(1'b0, 1'b1);
            count++;
        end
        checkOutput("lock-to-cke latency", 32'(count), 32'(LAT));
        for (int i = 0; i < 130; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 11; i++)
            checkOutput($sformatf("table cycle %0d", vecs[i].cyc),
                        32'(cap[vecs[i].cyc]), 32'(vecs[i].exp));

        $display("[TB] lock loss at cycle 105");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 105 + LAT; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < LAT; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("lock loss to inhibit", 32'(actualOut), 32'(RESET_VAL));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        clearCap();
        for (int i = 0; i < 125 + LAT; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 11; i++)
            checkOutput($sformatf("relock table cycle %0d", vecs[i].cyc),
                        32'(cap[vecs[i].cyc]), 32'(vecs[i].exp));

        $display("[TB] reset pulse mid power-up");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 50 + LAT; i++) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset mid powerup", 32'(actualOut), 32'(RESET_VAL));
        clearCap();
        for (int i = 0; i < 120 + LAT; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("post-reset cycle 99",  32'(cap[99]),  32'(vecs[1].exp));
        checkOutput("post-reset precharge", 32'(cap[100]), 32'(vecs[2].exp));
        checkOutput("post-reset load mode", 32'(cap[116]), 32'(vecs[7].exp));

        $display("[TB] random lock and reset traffic");
        lockState = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (lockState) begin
                if ($urandom_range(0, 149) == 0) lockState = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) lockState = 1'b1;
            end
            applyStimulus(($urandom_range(0, 799) == 0), lockState);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
